wb_ram_bridge: RTL and testbench
================================

// Module: wb_ram_bridge
// PURPOSE
//  Wishbone classic slave on clk_sys, directly downstream of the APF->Wishbone bridge master.
//  Converts single Wishbone read/write cycles into a simple req/busy memory port (SDRAM controller).
//  Checks the address window; returns err for out-of-range or timed-out accesses.
//  No bursts: cti/bte accepted but ignored; every access is treated as classic single (cti=0).
// PARAMETERS
//  BASE_WORD       30'h0   first Wishbone word address mapped to mem_addr 0
//  ADDR_W          24      memory word-address width; window = 2**ADDR_W words
//  TIMEOUT_CYCLES  255     max cycles waiting for mem_rdata_valid before err (8-bit counter, 1..255)
// PORTS
//  clk_sys          in   1       system clock, all logic on rising edge
//  reset            in   1       synchronous, active-high
//  addr             in   30      Wishbone word address
//  data_write       in   32      write data
//  sel              in   4       byte enables, bit n -> data[8n+7:8n]
//  cyc, stb, we     in   1 each  Wishbone cycle, strobe, write enable
//  cti / bte        in   3 / 2   ignored
//  data_read        out  32      read data, valid while ack=1
//  ack, err         out  1 each  one-cycle termination pulses, mutually exclusive
//  mem_addr         out  ADDR_W  word address = addr - BASE_WORD (low ADDR_W bits)
//  mem_wdata        out  32      registered copy of data_write
//  mem_wmask        out  4       registered copy of sel
//  mem_wr, mem_rd   out  1 each  request strobes, held until accepted
//  mem_busy         in   1       request accepted on cycle where (mem_wr|mem_rd) & ~mem_busy
//  mem_rdata        in   32      read data
//  mem_rdata_valid  in   1       one-cycle pulse returning read data
// BEHAVIOUR
//  Reset: state=IDLE; ack, err, mem_wr, mem_rd = 0; data_read, mem_addr, mem_wdata, mem_wmask = 0; timer=0.
//  All outputs registered. States IDLE, ISSUE, WAIT_RD, DRAIN, RESP, GAP.
//  IDLE: on cyc&stb compute off = addr - BASE_WORD (30-bit, wraps); if off >= 2**ADDR_W -> RESP with err;
//    else latch mem_addr/wdata/wmask, set mem_wr=we or mem_rd=~we, -> ISSUE.
//  ISSUE: hold request; on accept (~mem_busy): drop strobe; write -> RESP(ack); read -> WAIT_RD, timer=0.
//    cyc low in ISSUE before accept: drop strobe, -> IDLE, no ack/err, no memory access.
//  WAIT_RD: timer++ each cycle; mem_rdata_valid -> latch data_read, RESP(ack).
//    timer reaches TIMEOUT_CYCLES -> RESP(err), data_read=0; a late valid is ignored in GAP/IDLE.
//    cyc low in WAIT_RD -> DRAIN (await valid or timeout, discard, -> IDLE, no ack/err).
//  RESP: ack or err high exactly 1 cycle -> GAP. GAP: 1 cycle, cyc/stb ignored -> IDLE
//    (master sees ack one edge late; GAP blocks re-acceptance of the stale stb).
//  Latency: write idle-to-ack = 2 cycles with mem_busy=0; read = 2 + memory read latency.
//  mem_rdata_valid outside WAIT_RD/DRAIN is ignored. Simultaneous valid and timeout in WAIT_RD: valid wins (ack).
//  reset mid-operation: immediate return to reset values; in-flight memory request abandoned.
// CONFIGURATION
//  WB_RAM_BRIDGE_STATS_EN defined: adds outputs stat_writes, stat_reads, stat_errs (16-bit each,
//    saturating, reset 0), incremented on the RESP cycle by outcome (ack&we, ack&~we, err).
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  wb_ram_bridge_pkg: state enum (IDLE, ISSUE, WAIT_RD, DRAIN, RESP, GAP),
//    WB_ADDR_W=30, WB_DATA_W=32, WB_SEL_W=4, STAT_W=16.
//  Single module, no sub-modules; timer and stats counters inline.
// TESTING
//  1 write addr=BASE_WORD+5, data=32'hDEADBEEF, sel=F, mem_busy=0 -> mem_wr 1 cycle, mem_addr=5,
//    mem_wdata=DEADBEEF, ack 1 cycle, no second access while stb lingers in GAP.
//  2 write with mem_busy high 4 cycles -> mem_wr held 5 cycles, fields stable, single ack after accept.
//  3 read addr=BASE_WORD+2, valid 3 cycles after accept with 32'h12345678 -> ack, data_read=12345678.
//  4 addr=BASE_WORD+2**ADDR_W (and BASE_WORD-1 when BASE_WORD>0) -> err 1 cycle, no mem_wr/mem_rd.
//  5 read, no valid -> err after TIMEOUT_CYCLES; late valid ignored; next write completes normally.
//  6 reset asserted during ISSUE and WAIT_RD -> all outputs to reset values next edge; stats (if EN) cleared.

Source files
------------

// File: rtl/wb_ram_bridge_pkg.sv
// Shared types and widths for the Wishbone-to-RAM bridge.
package wb_ram_bridge_pkg;

    localparam int WB_ADDR_W = 30;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;
    localparam int STAT_W    = 16;
    localparam int TIMER_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        DRAIN,
        RESP,
        GAP
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/wb_ram_bridge.sv
// Wishbone classic slave that turns single read/write cycles into a
// req/busy memory port, with address-window check and read timeout.
// Optional build macro WB_RAM_BRIDGE_STATS_EN adds saturating outcome counters.
module wb_ram_bridge
    import wb_ram_bridge_pkg::*;
#(
    parameter logic [WB_ADDR_W-1:0] BASE_WORD      = 30'h0,
    parameter int                   ADDR_W         = 24,
    parameter int                   TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [WB_ADDR_W-1:0] addr,
    input  logic [WB_DATA_W-1:0] data_write,
    input  logic [WB_SEL_W-1:0]  sel,
    input  logic                 cyc,
    input  logic                 stb,
    input  logic                 we,
    input  logic [2:0]           cti,
    input  logic [1:0]           bte,
    output logic [WB_DATA_W-1:0] data_read,
    output logic                 ack,
    output logic                 err,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WB_DATA_W-1:0] mem_wdata,
    output logic [WB_SEL_W-1:0]  mem_wmask,
    output logic                 mem_wr,
    output logic                 mem_rd,
    input  logic                 mem_busy,
    input  logic [WB_DATA_W-1:0] mem_rdata,
    input  logic                 mem_rdata_valid
`ifdef WB_RAM_BRIDGE_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_writes,
    output logic [STAT_W-1:0]    stat_reads,
    output logic [STAT_W-1:0]    stat_errs
`endif
);

    // Timeout fires on the last of TIMEOUT_CYCLES waiting edges; the timer
    // holds the number of waiting edges already elapsed.
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t               state, state_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic                 is_write, is_write_n;
    logic [WB_DATA_W-1:0] data_read_n;
    logic                 ack_n, err_n;
    logic [ADDR_W-1:0]    mem_addr_n;
    logic [WB_DATA_W-1:0] mem_wdata_n;
    logic [WB_SEL_W-1:0]  mem_wmask_n;
    logic                 mem_wr_n, mem_rd_n;

    logic [WB_ADDR_W-1:0] off;
    logic                 in_range;
    logic                 accepted;
    logic                 timed_out;
    logic                 unused_ok;

    assign off       = addr - BASE_WORD;
    assign in_range  = (off >> ADDR_W) == '0;
    assign accepted  = (mem_wr | mem_rd) & ~mem_busy;
    assign timed_out = (timer == TIMEOUT_LAST);
    assign unused_ok = ^{cti, bte};

    // State and all registered outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            is_write  <= 1'b0;
            data_read <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            is_write  <= is_write_n;
            data_read <= data_read_n;
            ack       <= ack_n;
            err       <= err_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_wmask <= mem_wmask_n;
            mem_wr    <= mem_wr_n;
            mem_rd    <= mem_rd_n;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        is_write_n  = is_write;
        data_read_n = data_read;
        ack_n       = 1'b0;
        err_n       = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_wmask_n = mem_wmask;
        mem_wr_n    = mem_wr;
        mem_rd_n    = mem_rd;

        unique case (state)
            IDLE: begin
                if (cyc && stb) begin
                    is_write_n = we;
                    if (in_range) begin
                        mem_addr_n  = ADDR_W'(off);
                        mem_wdata_n = data_write;
                        mem_wmask_n = sel;
                        mem_wr_n    = we;
                        mem_rd_n    = ~we;
                        state_n     = ISSUE;
                    end else begin
                        err_n       = 1'b1;
                        data_read_n = '0;
                        state_n     = RESP;
                    end
                end
            end
            ISSUE: begin
                if (accepted) begin
                    mem_wr_n = 1'b0;
                    mem_rd_n = 1'b0;
                    timer_n  = '0;
                    // An accepted access has already happened at the memory;
                    // if the master left meanwhile, a read must still be drained.
                    if (is_write) begin
                        if (cyc) begin
                            ack_n   = 1'b1;
                            state_n = RESP;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        state_n = cyc ? WAIT_RD : DRAIN;
                    end
                end else if (!cyc) begin
                    mem_wr_n = 1'b0;
                    mem_rd_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            WAIT_RD: begin
                timer_n = timer + TIMER_W'(1);
                if (!cyc) begin
                    state_n = (mem_rdata_valid || timed_out) ? IDLE : DRAIN;
                end else if (mem_rdata_valid) begin
                    data_read_n = mem_rdata;
                    ack_n       = 1'b1;
                    state_n     = RESP;
                end else if (timed_out) begin
                    data_read_n = '0;
                    err_n       = 1'b1;
                    state_n     = RESP;
                end
            end
            DRAIN: begin
                timer_n = timer + TIMER_W'(1);
                if (mem_rdata_valid || timed_out) begin
                    state_n = IDLE;
                end
            end
            RESP: state_n = GAP;
            GAP:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef WB_RAM_BRIDGE_STATS_EN
    // Outcome counters, bumped on the cycle the response is presented.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            stat_writes <= '0;
            stat_reads  <= '0;
            stat_errs   <= '0;
        end else if (state == RESP) begin
            if (ack && is_write)  stat_writes <= sat_inc(stat_writes);
            if (ack && !is_write) stat_reads  <= sat_inc(stat_reads);
            if (err)              stat_errs   <= sat_inc(stat_errs);
        end
    end
`endif

endmodule

// File: tb/tb_wb_ram_bridge.sv
// Self-checking bench for wb_ram_bridge: a transaction-level model predicts
// outcome, latency, data and memory accesses; a memory responder stands in
// for the SDRAM controller. Honours WB_RAM_BRIDGE_STATS_EN when defined.
module tb_wb_ram_bridge;

    localparam logic [29:0] BASE = 30'h100;
    localparam int          AW   = 8;
    localparam int          TMO  = 20;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [29:0] addr    = '0;
    logic [31:0] data_write = '0;
    logic [3:0]  sel     = '0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [2:0]  cti = 3'd0;
    logic [1:0]  bte = 2'd0;
    logic [31:0] data_read;
    logic        ack, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wr, mem_rd;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rdata_valid = 1'b0;
`ifdef WB_RAM_BRIDGE_STATS_EN
    logic [15:0] stat_writes, stat_reads, stat_errs;
`endif

    wb_ram_bridge #(
        .BASE_WORD(BASE),
        .ADDR_W(AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .addr(addr), .data_write(data_write),
        .sel(sel), .cyc(cyc), .stb(stb), .we(we), .cti(cti), .bte(bte),
        .data_read(data_read), .ack(ack), .err(err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_wr(mem_wr),
        .mem_rd(mem_rd), .mem_busy(mem_busy), .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid)
`ifdef WB_RAM_BRIDGE_STATS_EN
        , .stat_writes(stat_writes), .stat_reads(stat_reads), .stat_errs(stat_errs)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int n_resp = 0;
    int ew = 0, er = 0, ee = 0;

    always @(posedge clk_sys) cyc_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- memory responder (SDRAM stand-in) ----------------
    typedef struct {
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  m;
        int          held;
    } acc_t;

    acc_t        acc_q[$];
    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];
    int          busy_cfg = 0;
    int          lat_cfg = 0;
    bit          inject_valid = 0;
    int          age = 0;
    int          pend = 0;
    logic [7:0]  rd_a = '0;
    logic [7:0]  s_a;
    logic [31:0] s_d;
    logic [3:0]  s_m;
    logic [1:0]  s_k;

    always @(negedge clk_sys) begin
        if (reset) begin
            age = 0; pend = 0; mem_busy = 1'b0; mem_rdata_valid = 1'b0;
        end else begin
            mem_rdata_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rdata_valid = 1'b1;
                    mem_rdata = mem_arr[rd_a];
                end
            end
            if (inject_valid) begin
                mem_rdata_valid = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end
            if (mem_wr || mem_rd) begin
                if (age == 0) begin
                    s_a = mem_addr; s_d = mem_wdata; s_m = mem_wmask; s_k = {mem_wr, mem_rd};
                end else begin
                    chk("req_stable", {mem_addr, mem_wmask, 2'b00, mem_wr, mem_rd, 16'h0},
                        {s_a, s_m, 2'b00, s_k, 16'h0});
                    chk("req_wdata_stable", mem_wdata, s_d);
                end
                age++;
                if (age <= busy_cfg) begin
                    mem_busy = 1'b1;
                end else begin
                    mem_busy = 1'b0;
                    acc_q.push_back('{mem_wr, mem_addr, mem_wdata, mem_wmask, age});
                    if (mem_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wmask[b]) mem_arr[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                    end else begin
                        rd_a = mem_addr;
                        pend = lat_cfg;
                    end
                end
            end else begin
                age = 0;
                mem_busy = 1'b0;
            end
        end
    end

    // ---------------- per-cycle output compare ----------------
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (ack || err) begin
                n_resp++;
                chk("ack_err_exclusive", {31'h0, ack & err}, 32'h0);
            end
            if (mem_wr || mem_rd)
                chk("wr_rd_exclusive", {31'h0, mem_wr & mem_rd}, 32'h0);
        end
    end

    // ---------------- transaction with model prediction ----------------
    task automatic xfer(input string nm, input logic [29:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s,
                        input int busy, input int lat,
                        output int lat_m, output logic [31:0] dat_m);
        logic [29:0] off;
        logic        inr, exp_ack;
        int          exp_lat, exp_acc, acc0, r0, start;
        logic [31:0] exp_dat;
        bit          got;
        acc_t        r;

        off = a - BASE;
        inr = off < 30'(1 << AW);
        exp_dat = '0;
        if (!inr) begin
            exp_ack = 1'b0; exp_lat = 1; exp_acc = 0;
        end else if (w) begin
            exp_ack = 1'b1; exp_lat = 2 + busy; exp_acc = 1;
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[off[7:0]][8*b +: 8] = d[8*b +: 8];
        end else if (lat >= 1 && lat <= TMO) begin
            exp_ack = 1'b1; exp_lat = 2 + busy + lat; exp_acc = 1;
            exp_dat = ref_mem[off[7:0]];
        end else begin
            exp_ack = 1'b0; exp_lat = 2 + busy + TMO; exp_acc = 1;
        end
        if (exp_ack && w) ew++;
        else if (exp_ack) er++;
        else ee++;

        acc0 = acc_q.size();
        r0 = n_resp;
        busy_cfg = busy;
        lat_cfg = lat;
        @(posedge clk_sys); #1;
        addr = a; we = w; data_write = d; sel = s; cyc = 1'b1; stb = 1'b1;
        start = cyc_cnt;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk_sys);
            if (ack || err) got = 1;
        end
        lat_m = -1;
        dat_m = data_read;
        if (!got) begin
            chk({nm, " no_response"}, 32'h0, 32'h1);
        end else begin
            lat_m = cyc_cnt - start;
            chk({nm, " latency"}, lat_m, exp_lat);
            chk({nm, " ack"}, {31'h0, ack}, {31'h0, exp_ack});
            chk({nm, " err"}, {31'h0, err}, {31'h0, ~exp_ack});
            if (!w && inr) chk({nm, " data"}, data_read, exp_dat);
        end
        // master notices ack one edge late: stb lingers through the GAP edge
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        chk({nm, " pulse_width"}, {30'h0, ack, err}, 32'h0);
        @(posedge clk_sys); #1;
        cyc = 1'b0; stb = 1'b0;
        repeat (4) @(negedge clk_sys);
        chk({nm, " resp_count"}, n_resp - r0, 1);
        chk({nm, " access_count"}, acc_q.size() - acc0, exp_acc);
        if (exp_acc == 1 && acc_q.size() > acc0) begin
            r = acc_q[$];
            chk({nm, " acc_kind"}, {31'h0, r.wr}, {31'h0, w});
            chk({nm, " acc_addr"}, {24'h0, r.a}, {24'h0, off[7:0]});
            chk({nm, " acc_held"}, r.held, busy + 1);
            if (w) begin
                chk({nm, " acc_wdata"}, r.d, d);
                chk({nm, " acc_mask"}, {28'h0, r.m}, {28'h0, s});
            end
        end
    endtask

    task automatic reset_vals(input string nm);
        chk({nm, " strobes"}, {28'h0, ack, err, mem_wr, mem_rd}, 32'h0);
        chk({nm, " data_read"}, data_read, 32'h0);
        chk({nm, " mem_addr"}, {24'h0, mem_addr}, 32'h0);
        chk({nm, " mem_wdata"}, mem_wdata, 32'h0);
        chk({nm, " mem_wmask"}, {28'h0, mem_wmask}, 32'h0);
`ifdef WB_RAM_BRIDGE_STATS_EN
        chk({nm, " stats"}, {stat_writes, stat_reads}, 32'h0);
        chk({nm, " stat_errs"}, {16'h0, stat_errs}, 32'h0);
`endif
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        @(negedge clk_sys);
        reset_vals(nm);
        reset = 1'b0;
        cyc = 1'b0; stb = 1'b0;
        busy_cfg = 0; lat_cfg = 0;
        ew = 0; er = 0; ee = 0;
        repeat (2) @(negedge clk_sys);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          l;
        logic [31:0] dv;
        int          r0, a0;

        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end
        mem_arr[2] = 32'h12345678;
        ref_mem[2] = 32'h12345678;

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_vals("reset_initial");
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // 1: simple write
        xfer("wr_simple", BASE + 30'd5, 1'b1, 32'hDEADBEEF, 4'hF, 0, 0, l, dv);
        chk("wr_simple lit_latency", l, 2);
        chk("wr_simple lit_addr", {24'h0, acc_q[$].a}, 32'd5);
        chk("wr_simple lit_wdata", acc_q[$].d, 32'hDEADBEEF);

        // 2: write stalled by busy
        xfer("wr_busy", BASE + 30'd6, 1'b1, 32'hCAFEF00D, 4'hF, 4, 0, l, dv);
        chk("wr_busy lit_latency", l, 6);
        chk("wr_busy lit_held", acc_q[$].held, 5);

        // 3: read with 3-cycle memory latency
        xfer("rd_lat3", BASE + 30'd2, 1'b0, 32'h0, 4'hF, 0, 3, l, dv);
        chk("rd_lat3 lit_latency", l, 5);
        chk("rd_lat3 lit_data", dv, 32'h12345678);

        // byte-masked write then readback
        xfer("wr_mask", BASE + 30'd5, 1'b1, 32'h11223344, 4'b0010, 1, 0, l, dv);
        xfer("rd_mask", BASE + 30'd5, 1'b0, 32'h0, 4'hF, 2, 1, l, dv);
        chk("rd_mask lit_data", dv, 32'hDEAD33EF);

        // valid on the very last waiting cycle beats the timeout
        xfer("rd_edge", BASE + 30'd6, 1'b0, 32'h0, 4'hF, 0, TMO, l, dv);
        chk("rd_edge lit_data", dv, 32'hCAFEF00D);

        // 4: address window boundaries
        xfer("win_top", BASE + 30'd255, 1'b1, 32'h0BADF00D, 4'hF, 0, 0, l, dv);
        xfer("win_over", BASE + 30'd256, 1'b1, 32'h11111111, 4'hF, 0, 0, l, dv);
        chk("win_over lit_latency", l, 1);
        xfer("win_under", BASE - 30'd1, 1'b0, 32'h0, 4'hF, 0, 3, l, dv);

        // 5: timeouts, late valids ignored, then normal write
        xfer("rd_timeout", BASE + 30'd2, 1'b0, 32'h0, 4'hF, 0, 0, l, dv);
        chk("rd_timeout lit_latency", l, 2 + TMO);
        chk("rd_timeout lit_data", dv, 32'h0);
        xfer("rd_late1", BASE + 30'd2, 1'b0, 32'h0, 4'hF, 0, TMO + 1, l, dv);
        xfer("rd_late2", BASE + 30'd2, 1'b0, 32'h0, 4'hF, 0, TMO + 2, l, dv);
        r0 = n_resp;
        inject_valid = 1;
        @(negedge clk_sys);
        inject_valid = 0;
        repeat (3) @(negedge clk_sys);
        chk("idle_valid resp_count", n_resp - r0, 0);
        chk("idle_valid data_read", data_read, 32'h0);
        xfer("wr_after_to", BASE + 30'd7, 1'b1, 32'hA5A5A5A5, 4'hF, 0, 0, l, dv);

        // master withdraws while request is stalled
        r0 = n_resp; a0 = acc_q.size();
        busy_cfg = 1000;
        @(posedge clk_sys); #1;
        addr = BASE + 30'd3; we = 1'b1; data_write = 32'h77777777; sel = 4'hF;
        cyc = 1'b1; stb = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("abort mem_wr_held", {31'h0, mem_wr}, 32'h1);
        @(posedge clk_sys); #1;
        cyc = 1'b0; stb = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("abort mem_wr_dropped", {31'h0, mem_wr}, 32'h0);
        chk("abort resp_count", n_resp - r0, 0);
        chk("abort access_count", acc_q.size() - a0, 0);
        busy_cfg = 0;

`ifdef WB_RAM_BRIDGE_STATS_EN
        chk("stat_writes", {16'h0, stat_writes}, ew);
        chk("stat_reads", {16'h0, stat_reads}, er);
        chk("stat_errs", {16'h0, stat_errs}, ee);
`endif

        // 6: reset during ISSUE
        busy_cfg = 1000;
        @(posedge clk_sys); #1;
        addr = BASE + 30'd9; we = 1'b1; data_write = 32'h5555AAAA; sel = 4'hC;
        cyc = 1'b1; stb = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("rst_issue mem_wr_pre", {31'h0, mem_wr}, 32'h1);
        do_reset("rst_issue");

        // reset during WAIT_RD
        lat_cfg = 0;
        @(posedge clk_sys); #1;
        addr = BASE + 30'd2; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        repeat (5) @(negedge clk_sys);
        chk("rst_wait mem_addr_pre", {24'h0, mem_addr}, 32'd2);
        do_reset("rst_wait");

        xfer("wr_after_rst", BASE + 30'd8, 1'b1, 32'h01020304, 4'hF, 1, 0, l, dv);
        xfer("rd_after_rst", BASE + 30'd8, 1'b0, 32'h0, 4'hF, 0, 2, l, dv);
        chk("rd_after_rst lit_data", dv, 32'h01020304);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
